// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM encoding and
// default datapath sizes.
package exec_pkg;

    localparam int EXEC_WIDTH = 16;
    localparam int EXEC_AW    = 3;
    localparam int EXEC_CNT_W = 5;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLL  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_DIVU = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    // MUL and DIVU run on the iterative datapath; everything else is single-cycle.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/exec_if.sv
// Issue/writeback bundle between control logic, execute stage and register file.
interface exec_if import exec_pkg::*; #(
    parameter int WIDTH = EXEC_WIDTH,
    parameter int AW    = EXEC_AW
);
    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    dst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             carry;

    modport master (
        output start, op, dst, a, b,
        input  busy, done, we, wa, wd, carry
    );

    modport slave (
        input  start, op, dst, a, b,
        output busy, done, we, wa, wd, carry
    );
endinterface

// File: rtl/exec_iter.sv
// Iterative MUL (shift-add, LSB first) / DIVU (restoring, MSB first) datapath.
// acc_q is the product accumulator for MUL and the partial remainder for DIVU;
// opa_q is the shifting multiplicand / dividend-becoming-quotient;
// opb_q is the shifting multiplier / fixed divisor.
module exec_iter import exec_pkg::*; #(
    parameter int WIDTH = EXEC_WIDTH,
    parameter int CNT_W = EXEC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] result_o,
    output logic             last_o
);
    logic [WIDTH-1:0] acc_q, opa_q, opb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // One iteration of each algorithm; result_o already includes the current step
    // so the FSM can capture the final value on the last iteration edge.
    always_comb begin
        mul_acc  = opb_q[0] ? (acc_q + opa_q) : acc_q;
        rem_sh   = {acc_q, opa_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        q_bit    = ~rem_diff[WIDTH];
        // A zero divisor never borrows, so every quotient bit is 1 (all-ones result).
        rem_next = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {opa_q[WIDTH-2:0], q_bit};
        result_o = div_q ? quo_next : mul_acc;
        last_o   = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Operand load on issue, then one bit per cycle while the FSM is iterating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= '0;
            opa_q <= a_i;
            opb_q <= b_i;
            cnt_q <= '0;
            div_q <= is_div_i;
        end else if (step_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (div_q) begin
                acc_q <= rem_next;
                opa_q <= quo_next;
            end else begin
                acc_q <= mul_acc;
                opa_q <= opa_q << 1;
                opb_q <= opb_q >> 1;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle logic/arith ops, 16-cycle MUL/DIVU, and the
// register-file writeback pulse.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | waiting for start; single-cycle ops resolve here
//   MUL     | shift-add iterations in exec_iter
//   DIV     | restoring-divide iterations in exec_iter
//   WB      | done/we pulse for one cycle, then back to IDLE
module exec_unit import exec_pkg::*; #(
    parameter int WIDTH = EXEC_WIDTH,
    parameter int AW    = EXEC_AW,
    parameter int CNT_W = EXEC_CNT_W
) (
    input  logic  clk,
    input  logic  rst_n,
    exec_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [AW-1:0]    wa_q, wa_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic             carry_q, carry_d;

    logic             accept;
    logic             iter_load;
    logic             iter_step;
    logic [WIDTH-1:0] iter_result;
    logic             iter_last;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    assign accept    = (state_q == ST_IDLE) && bus.start;
    assign iter_load = accept && is_iter_op(bus.op);
    assign iter_step = (state_q == ST_MUL) || (state_q == ST_DIV);

    exec_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (iter_load),
        .is_div_i (bus.op == OP_DIVU),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .step_i   (iter_step),
        .result_o (iter_result),
        .last_o   (iter_last)
    );

    // Single-cycle ALU straight off the operand inputs; only sampled on accept.
    always_comb begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res = '0;
        alu_c   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SLL:  alu_res = bus.a << bus.b[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // Next-state and result capture; wa/wd/carry only change on completion so
    // they hold the previous result while an iterative op is in flight.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        wa_d    = wa_q;
        dst_d   = dst_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dst_d = bus.dst;
                    if (bus.op == OP_MUL) begin
                        state_d = ST_MUL;
                    end else if (bus.op == OP_DIVU) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_WB;
                        wd_d    = alu_res;
                        wa_d    = bus.dst;
                        carry_d = alu_c;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (iter_last) begin
                    state_d = ST_WB;
                    wd_d    = iter_result;
                    wa_d    = dst_q;
                    carry_d = 1'b0;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
            wa_q    <= '0;
            dst_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            wa_q    <= wa_d;
            dst_q   <= dst_d;
            carry_q <= carry_d;
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = (state_q == ST_WB);
    assign bus.we    = bus.done && (wa_q != '0);
    assign bus.wa    = wa_q;
    assign bus.wd    = wd_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: the stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever done is seen.
module tb_exec_unit;
    import exec_pkg::*;

    typedef struct {
        logic [15:0] wd;
        logic [2:0]  wa;
        logic        carry;
        logic        we;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exec_if bus ();

    exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   nb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("wd", 32'(bus.wd), 32'(mon_e.wd));
                chk("wa", 32'(bus.wa), 32'(mon_e.wa));
                chk("carry", 32'(bus.carry), 32'(mon_e.carry));
                chk("we", 32'(bus.we), 32'(mon_e.we));
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] dst, input bit expect_it,
                         input logic [15:0] ewd, input logic ec);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.dst   = dst;
        if (expect_it) begin
            e.wd    = ewd;
            e.wa    = dst;
            e.carry = ec;
            e.we    = (dst != 3'd0);
            e.cyc   = cyc + 1 + (((op == OP_MUL) || (op == OP_DIVU)) ? 16 : 0);
            sb.push_back(e);
        end
        @(negedge clk);
        // Scramble inputs after acceptance; the latched values must be used.
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        bus.dst   = 3'd7;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (n >= 60) begin
            n_chk++;
            $display("FAIL busy_timeout: got busy after %0d cycles want idle", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;
        bus.dst   = '0;

        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start = i[0];
            bus.op    = 3'(i);
            bus.a     = 16'h1111 * 16'(i);
            bus.b     = 16'h0101 * 16'(i);
            bus.dst   = 3'(i);
        end
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_we", 32'(bus.we), 0);
        chk("rst_wd", 32'(bus.wd), 0);
        chk("rst_wa", 32'(bus.wa), 0);
        chk("rst_carry", 32'(bus.carry), 0);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;

        issue(OP_ADD, 16'h0003, 16'h0004, 3'd2, 1, 16'h0007, 1'b0);
        wait_idle(nb);
        chk("busy_add", 32'(nb), 1);
        issue(OP_ADD, 16'hFFFF, 16'h0001, 3'd1, 1, 16'h0000, 1'b1);
        wait_idle(nb);
        issue(OP_SUB, 16'h0002, 16'h0005, 3'd3, 1, 16'hFFFD, 1'b0);
        wait_idle(nb);
        issue(OP_SUB, 16'h0005, 16'h0005, 3'd4, 1, 16'h0000, 1'b1);
        wait_idle(nb);
        issue(OP_SLL, 16'h0001, 16'h0013, 3'd6, 1, 16'h0008, 1'b0);
        wait_idle(nb);
        issue(OP_AND, 16'hF0F0, 16'h0FF0, 3'd7, 1, 16'h00F0, 1'b0);
        wait_idle(nb);
        issue(OP_OR, 16'hF0F0, 16'h0FF0, 3'd7, 1, 16'hFFF0, 1'b0);
        wait_idle(nb);
        issue(OP_XOR, 16'hF0F0, 16'h0FF0, 3'd5, 1, 16'hFF00, 1'b0);
        wait_idle(nb);

        issue(OP_MUL, 16'h0123, 16'h0010, 3'd5, 1, 16'h1230, 1'b0);
        wait_idle(nb);
        chk("busy_mul", 32'(nb), 17);
        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 3'd3, 1, 16'h0001, 1'b0);
        wait_idle(nb);
        issue(OP_DIVU, 16'h0064, 16'h0007, 3'd2, 1, 16'h000E, 1'b0);
        wait_idle(nb);
        chk("busy_div", 32'(nb), 17);
        issue(OP_DIVU, 16'h1234, 16'h0000, 3'd4, 1, 16'hFFFF, 1'b0);
        wait_idle(nb);
        chk("busy_div0", 32'(nb), 17);

        // start during MUL must be dropped, not queued.
        issue(OP_MUL, 16'h0003, 16'h0005, 3'd1, 1, 16'h000F, 1'b0);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.dst   = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(nb);
        repeat (4) @(negedge clk);
        chk("no_queued_start", 32'(sb.size()), 0);

        issue(OP_ADD, 16'h0001, 16'h0001, 3'd0, 1, 16'h0002, 1'b0);
        wait_idle(nb);

        // Reset at iteration 8 of a DIVU: aborted, never written back.
        issue(OP_DIVU, 16'h00FF, 16'h0003, 3'd6, 0, 16'h0000, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_we", 32'(bus.we), 0);
        chk("midrst_wd", 32'(bus.wd), 0);
        chk("midrst_wa", 32'(bus.wa), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        issue(OP_ADD, 16'h0010, 16'h0020, 3'd6, 1, 16'h0030, 1'b0);
        wait_idle(nb);
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
